// File: rtl/posit_pkg.sv
// Shared posit constants, batch framing parameters and FSM state type for the
// accumulator front end.
package posit_pkg;

    localparam int N     = 32;
    localparam int es    = 2;
    localparam int BATCH = 8;

    localparam int IDX_W = $clog2(BATCH);
    // One extra bit so a full group (cnt == BATCH) is representable.
    localparam int CNT_W = IDX_W + 1;

    typedef logic [N-1:0] posit_t;

    localparam posit_t POSIT_ZERO = '0;
    localparam posit_t POSIT_NAR  = {1'b1, {(N-1){1'b0}}};

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(BATCH - 1);

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        WAIT,
        OUT
    } batch_state_t;

    // Terms at or beyond the group length read as posit zero.
    function automatic posit_t mask_term(input posit_t term, input logic keep);
        return keep ? term : POSIT_ZERO;
    endfunction

endpackage

// File: rtl/posit_accum_batcher_if.sv
// Bundles the term input stream, the accumulator drive/return bus and the
// result output stream of the batcher.
interface posit_accum_batcher_if
    import posit_pkg::*;
();

    logic                 s_valid;
    logic                 s_ready;
    posit_t               s_data;
    logic                 s_last;

    posit_t               acc_in;
    logic                 acc_start;
    posit_t               acc_result;
    logic                 acc_inf;
    logic                 acc_zero;
    logic                 acc_done;

    logic                 m_valid;
    logic                 m_ready;
    posit_t               m_result;
    logic                 m_inf;
    logic                 m_zero;
    logic [CNT_W-1:0]     m_count;

    // Batcher side.
    modport master (
        input  s_valid, s_data, s_last,
        output s_ready,
        output acc_in, acc_start,
        input  acc_result, acc_inf, acc_zero, acc_done,
        output m_valid, m_result, m_inf, m_zero, m_count,
        input  m_ready
    );

    // Environment side: term source, accumulator and result sink.
    modport slave (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  acc_in, acc_start,
        output acc_result, acc_inf, acc_zero, acc_done,
        input  m_valid, m_result, m_inf, m_zero, m_count,
        output m_ready
    );

endinterface

// File: rtl/posit_batch_buf.sv
// Eight-entry term store: indexed write while filling, indexed read masked so
// that slots at or past the group length return posit zero.
module posit_batch_buf
    import posit_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  posit_t           wdata,
    input  logic [IDX_W-1:0] raddr,
    input  logic [CNT_W-1:0] cnt,
    output posit_t           rdata
);

    posit_t mem [BATCH];

    // NOTE: the storage array has no reset; stale slots from an earlier group
    // are hidden by the cnt mask on read, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mask_term(mem[raddr], ({1'b0, raddr} < cnt));

endmodule

// File: rtl/posit_accum_batcher.sv
// Frames a posit term stream into zero-padded batches of eight, drives them
// into the accumulator back to back and returns the captured result.
module posit_accum_batcher
    import posit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    posit_accum_batcher_if.master bus
);

    batch_state_t       state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   k;

    logic               s_ready_q;
    logic               acc_start_q;
    logic               m_valid_q;
    posit_t             m_result_q;
    logic               m_inf_q;
    logic               m_zero_q;
    logic [CNT_W-1:0]   m_count_q;

    posit_t             rd_term;
    logic               accept;
    logic               group_close;

    assign accept      = bus.s_valid && s_ready_q && (state == FILL);
    assign group_close = accept && (bus.s_last || (cnt == CNT_LAST));

    posit_batch_buf u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (cnt[IDX_W-1:0]),
        .wdata (bus.s_data),
        .raddr (k),
        .cnt   (cnt),
        .rdata (rd_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            k           <= '0;
            s_ready_q   <= 1'b0;
            acc_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_result_q  <= POSIT_ZERO;
            m_inf_q     <= 1'b0;
            m_zero_q    <= 1'b0;
            m_count_q   <= '0;
        end else begin
            // NOTE: all state here updates with <= so every branch sees the
            // pre-edge values of cnt, k and state regardless of statement order.
            unique case (state)
                FILL: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (group_close) begin
                            state       <= ISSUE;
                            k           <= '0;
                            s_ready_q   <= 1'b0;
                            acc_start_q <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (k == K_LAST) begin
                        state       <= WAIT;
                        k           <= '0;
                        acc_start_q <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end

                // Only a done seen here belongs to the batch just issued.
                WAIT: begin
                    if (bus.acc_done) begin
                        m_result_q <= bus.acc_result;
                        m_inf_q    <= bus.acc_inf;
                        m_zero_q   <= bus.acc_zero;
                        m_count_q  <= cnt;
                        m_valid_q  <= 1'b1;
                        state      <= OUT;
                    end
                end

                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        cnt       <= '0;
                        s_ready_q <= 1'b1;
                        state     <= FILL;
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.acc_start = acc_start_q;
    // Gating by the registered strobe keeps acc_in at zero outside ISSUE and
    // lets it fall with acc_start when reset hits mid-batch.
    assign bus.acc_in    = acc_start_q ? rd_term : POSIT_ZERO;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_result  = m_result_q;
    assign bus.m_inf     = m_inf_q;
    assign bus.m_zero    = m_zero_q;
    assign bus.m_count   = m_count_q;

endmodule

// File: doc/posit_accum_batcher.md
# posit_accum_batcher

Upstream framing stage for the 8-term posit accumulator (`positaccum_8`). It accepts posit terms from a valid/ready stream and groups them into batches of exactly 8, zero-padding short groups. It drives each batch into the accumulator on eight consecutive cycles, then captures the accumulator result and flags and returns them on an output valid/ready stream. It sits between the PairHMM result stream and the accumulator, so the accumulator never sees partial or stalled batches.

## Interface
- `N`, 32, posit width
- `es`, 2, posit exponent size (carried for package consistency; unused in datapath)
- `BATCH`, 8, terms per accumulator batch (fixed to the accumulator depth)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  input term valid
- `s_ready`  out  1  input term accepted when `s_valid && s_ready`
- `s_data`  in  N  posit term
- `s_last`  in  1  term closes the current group
- `acc_in`  out  N  term to accumulator
- `acc_start`  out  1  term-valid strobe to accumulator
- `acc_result`  in  N  accumulator result
- `acc_inf`  in  1  accumulator NaR flag
- `acc_zero`  in  1  accumulator zero flag
- `acc_done`  in  1  accumulator result valid
- `m_valid`  out  1  batch result valid
- `m_ready`  in  1  downstream accepts result
- `m_result`  out  N  captured result
- `m_inf`, `m_zero`  out  1  captured flags
- `m_count`  out  4  real (unpadded) terms in the batch, 1..8

## Operation
- FSM states: FILL, ISSUE, WAIT, OUT. Reset state is FILL.
- **FILL**
  - `s_ready`=1.
  - Each accepted term is written to `buf[cnt]` and `cnt` increments.
  - The group closes when the accepted term has `s_last`=1 or `cnt` reaches 8; the next state is ISSUE.
  - A 9th term without `s_last` starts a new group; no error is raised.
  - On close, `buf[cnt..7]` read as 0 (posit zero). This is done by masking on read, not by clearing.
- **ISSUE**
  - Lasts exactly 8 cycles, `k`=0..7.
  - `acc_start`=1 and `acc_in`=`buf[k]` (or 0 if `k`>=`cnt`).
  - After `k`=7 the next state is WAIT.
  - `s_ready`=0.
- **WAIT**
  - `acc_start`=0 and `acc_in`=0.
  - On the first cycle with `acc_done`=1, register `acc_result`/`acc_inf`/`acc_zero` into `m_*`; the next state is OUT.
  - `acc_done` is ignored in every other state.
- **OUT**
  - `m_valid`=1; `m_*` and `m_count` are held stable.
  - On `m_valid && m_ready`: clear `cnt`, next state FILL.
- NaR input terms (`1` followed by zeros) pass through unmodified; the block does no arithmetic.

## Timing
- Reset values: `s_ready`=0 during `rst`, 1 on the first cycle after release. `acc_start`=0, `acc_in`=0, `m_valid`=0, `m_result`=0, `m_inf`=0, `m_zero`=0, `m_count`=0, `cnt`=0, `k`=0.
- Reset asserted in any state (including mid-ISSUE or mid-OUT) returns the block to FILL immediately.
  - The partial group is discarded.
  - `acc_start` drops asynchronously.
- Closing beat accepted at cycle t → `acc_start` high for cycles t+1..t+8.
- `acc_done` seen at cycle d → `m_valid` high from d+1.
- Handshake in OUT at cycle h → `s_ready` high at h+1.
- `m_valid` never drops without a handshake.
- `s_ready` is a registered state decode, with no combinational path from `m_ready`.
- No overlap: a new group is not accepted until the previous result is consumed.

## Structure
- Shared package `posit_pkg` holds:
  - `N`, `es`
  - `BATCH`
  - `POSIT_ZERO` (all zeros) and `POSIT_NAR` (MSB only) constants
  - the enum `batch_state_t` {FILL, ISSUE, WAIT, OUT}
- One natural sub-module, `posit_batch_buf`: 8×N register file with write-by-index and masked read-by-index (returns 0 for index >= `cnt`).
- The top level contains the FSM, the `cnt`/`k` counters and the result capture registers.

## Test plan
- **Full group.** 8 beats of 32'h40000000 (1.0), `s_last` on the 8th.
  - Expect `acc_in`=32'h40000000 on 8 consecutive `acc_start` cycles.
  - Drive `acc_result`=32'h60000000 with `acc_done` → `m_result`=32'h60000000, `m_count`=8.
- **Short group.** 3 beats 32'h1C015021, `s_last` on the 3rd.
  - Expect 3 cycles of `acc_in`=32'h1C015021, then 5 cycles of `acc_in`=0; `m_count`=3.
- **Auto-close.** 9 beats without `s_last`.
  - First batch closes after beat 8; `s_ready`=0 until the OUT handshake.
  - Beat 9 lands in the second batch; on `s_last` that batch gives `m_count`=1.
- **Backpressure and flags.**
  - Hold `m_ready`=0 for 20 cycles → `m_valid` and `m_result` stable, `s_ready`=0.
  - `acc_inf`=1 captured → `m_inf`=1, `m_result`=32'h80000000.
- **Spurious done.** Pulse `acc_done` during FILL and during ISSUE.
  - Expect no `m_valid`.
  - The real result is captured only in WAIT.
- **Reset mid-operation.** Assert `rst` at ISSUE cycle `k`=4.
  - `acc_start`=0 immediately and all outputs take their reset values.
  - After release a fresh 2-term group is issued correctly with `m_count`=2.
